// File: rtl/pixel_fetch_sequencer.sv
// pixel_fetch_sequencer
//   Turns DTG scan coordinates into world-map and icon ROM addresses, latches
//   the robot position/heading once per frame, masks the icon to the 16x16
//   window around the robot, and delays the DTG flags so that every colorizer
//   input lands on the same clock. Total latency is RD_LAT + 2 clocks.
//
// Ports
//   clk, reset                 pixel clock, synchronous active-high reset
//   pixel_row, pixel_column    DTG scan position
//   video_on_in/hsync_in/vsync_in  DTG flags, delayed to *_out
//   loc_x, loc_y, orient       robot map position and heading (sampled at frame start)
//   world_addr, world_data     world-map ROM address / data (data RD_LAT clks later)
//   icon_addr, icon_data       icon ROM address / data (data RD_LAT clks later)
//   world_pixel, icon          colorizer inputs; icon 2'b00 = transparent
module pixel_fetch_sequencer #(
   parameter int RD_LAT = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [9:0]  pixel_row,
   input  logic [9:0]  pixel_column,
   input  logic        video_on_in,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic [6:0]  loc_x,
   input  logic [6:0]  loc_y,
   input  logic [2:0]  orient,
   output logic [13:0] world_addr,
   output logic [10:0] icon_addr,
   input  logic [1:0]  world_data,
   input  logic [1:0]  icon_data,
   output logic [1:0]  world_pixel,
   output logic [1:0]  icon,
   output logic        video_on_out,
   output logic        hsync_out,
   output logic        vsync_out
);

   typedef struct packed {
      logic vid;
      logic hs;
      logic vs;
      logic hit;
   } dly_t;

   logic [9:0]  prev_row;
   logic [6:0]  map_row, map_row_n;
   logic [2:0]  row_sub, row_sub_n;
   logic [6:0]  loc_x_l, loc_y_l;
   logic [2:0]  orient_l;

   logic        row_change, frame_start;
   logic [6:0]  lx, ly;
   logic [2:0]  lo;
   logic [11:0] x0, y0, dx, dy;
   logic        hit;

   dly_t [RD_LAT:0] dly_pipe;

   assign row_change  = (pixel_row != prev_row);
   assign frame_start = row_change && (pixel_row == 10'd0);

   // The frame latch must already apply to the first pixel of row 0, so the
   // window math uses the incoming values on the frame-start cycle.
   assign lx = frame_start ? loc_x  : loc_x_l;
   assign ly = frame_start ? loc_y  : loc_y_l;
   assign lo = frame_start ? orient : orient_l;

   // 6 screen rows per map row: row_sub counts 0..5 within a map row.
   always_comb begin
      map_row_n = map_row;
      row_sub_n = row_sub;
      if (frame_start) begin
         map_row_n = 7'd0;
         row_sub_n = 3'd0;
      end else if (row_change) begin
         if (row_sub == 3'd5) begin
            row_sub_n = 3'd0;
            if (map_row != 7'd127) map_row_n = map_row + 7'd1;
         end else begin
            row_sub_n = row_sub + 3'd1;
         end
      end
   end

   // Window origin: x0 = 8x-4, y0 = 6y-5 in 12-bit two's complement. A negative
   // dx/dy sets the upper bits, so "upper bits zero" is exactly 0 <= d < 16 and
   // off-screen parts of the window clip with no wrap.
   assign x0  = {2'b00, lx, 3'b000} - 12'd4;
   assign y0  = ({3'b000, ly, 2'b00} + {4'b0000, ly, 1'b0}) - 12'd5;
   assign dx  = {2'b00, pixel_column} - x0;
   assign dy  = {2'b00, pixel_row} - y0;
   assign hit = (dx[11:4] == 8'd0) && (dy[11:4] == 8'd0) && video_on_in;

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_row     <= '0;
         map_row      <= '0;
         row_sub      <= '0;
         loc_x_l      <= '0;
         loc_y_l      <= '0;
         orient_l     <= '0;
         world_addr   <= '0;
         icon_addr    <= '0;
         dly_pipe     <= '0;
         world_pixel  <= '0;
         icon         <= '0;
         video_on_out <= 1'b0;
         hsync_out    <= 1'b0;
         vsync_out    <= 1'b0;
      end else begin
         prev_row <= pixel_row;
         map_row  <= map_row_n;
         row_sub  <= row_sub_n;
         if (frame_start) begin
            loc_x_l  <= loc_x;
            loc_y_l  <= loc_y;
            orient_l <= orient;
         end

         // Stage A
         world_addr <= {map_row_n, pixel_column[9:3]};
         icon_addr  <= hit ? {lo, dy[3:0], dx[3:0]} : 11'd0;

         // dly_pipe[RD_LAT] lines up with ROM data for the output register.
         dly_pipe[0] <= '{vid: video_on_in, hs: hsync_in, vs: vsync_in, hit: hit};
         for (int i = 1; i <= RD_LAT; i++) dly_pipe[i] <= dly_pipe[i-1];

         // Output stage
         world_pixel  <= dly_pipe[RD_LAT].vid ? world_data : 2'b00;
         icon         <= dly_pipe[RD_LAT].hit ? icon_data  : 2'b00;
         video_on_out <= dly_pipe[RD_LAT].vid;
         hsync_out    <= dly_pipe[RD_LAT].hs;
         vsync_out    <= dly_pipe[RD_LAT].vs;
      end
   end

endmodule

// File: tb/tb_pixel_fetch_sequencer.sv
module tb_pixel_fetch_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [9:0]  pixel_row = '0, pixel_column = '0;
   logic        video_on_in = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
   logic [6:0]  loc_x = '0, loc_y = '0;
   logic [2:0]  orient = '0;

   logic [13:0] wa1, wa3;
   logic [10:0] ia1, ia3;
   logic [1:0]  wd1 = '0, id1 = '0, wp1, ic1, wp3, ic3;
   logic [2:0][1:0] w3p = '0, i3p = '0;
   logic        vo1, hs1, vs1, vo3, hs3, vs3;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pixel_fetch_sequencer #(.RD_LAT(1)) dut1 (
      .clk(clk), .reset(reset), .pixel_row(pixel_row), .pixel_column(pixel_column),
      .video_on_in(video_on_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
      .loc_x(loc_x), .loc_y(loc_y), .orient(orient),
      .world_addr(wa1), .icon_addr(ia1), .world_data(wd1), .icon_data(id1),
      .world_pixel(wp1), .icon(ic1), .video_on_out(vo1), .hsync_out(hs1), .vsync_out(vs1));

   pixel_fetch_sequencer #(.RD_LAT(3)) dut3 (
      .clk(clk), .reset(reset), .pixel_row(pixel_row), .pixel_column(pixel_column),
      .video_on_in(video_on_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
      .loc_x(loc_x), .loc_y(loc_y), .orient(orient),
      .world_addr(wa3), .icon_addr(ia3), .world_data(w3p[2]), .icon_data(i3p[2]),
      .world_pixel(wp3), .icon(ic3), .video_on_out(vo3), .hsync_out(hs3), .vsync_out(vs3));

   // ROM models: world data = low two address bits, icon data never 00.
   function automatic logic [1:0] wf(input logic [13:0] a);
      return a[1:0];
   endfunction
   function automatic logic [1:0] icf(input logic [10:0] a);
      return a[0] ? 2'b01 : 2'b10;
   endfunction

   always @(posedge clk) begin
      wd1 <= wf(wa1);
      id1 <= icf(ia1);
      w3p <= {w3p[1:0], wf(wa3)};
      i3p <= {i3p[1:0], icf(ia3)};
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic hold();
      repeat (5) step();
   endtask

   task automatic pix(input int r, input int c);
      pixel_row    = 10'(r);
      pixel_column = 10'(c);
   endtask

   task automatic test_reset();
      int n1, n3;
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         pixel_row    = 10'($urandom_range(0, 767));
         pixel_column = 10'($urandom_range(0, 1023));
         video_on_in  = 1'($urandom);
         hsync_in     = 1'($urandom);
         vsync_in     = 1'($urandom);
         loc_x        = 7'($urandom);
         loc_y        = 7'($urandom);
         orient       = 3'($urandom);
         step();
      end
      checks++;
      if ({wa1, ia1, wp1, ic1, vo1, hs1, vs1} !== 32'd0) begin
         failures++;
         $display("FAIL reset_outs_lat1 got=%h exp=0", {wa1, ia1, wp1, ic1, vo1, hs1, vs1});
      end
      checks++;
      if ({wa3, ia3, wp3, ic3, vo3, hs3, vs3} !== 32'd0) begin
         failures++;
         $display("FAIL reset_outs_lat3 got=%h exp=0", {wa3, ia3, wp3, ic3, vo3, hs3, vs3});
      end
      reset = 1'b0;
      pix(0, 0);
      video_on_in = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
      loc_x = '0; loc_y = '0; orient = '0;
      n1 = -1; n3 = -1;
      for (int k = 1; k <= 8; k++) begin
         step();
         if (n1 < 0 && vo1 === 1'b1) n1 = k;
         if (n3 < 0 && vo3 === 1'b1) n3 = k;
      end
      checks++;
      if (n1 != 3) begin
         failures++;
         $display("FAIL latency_lat1 got=%0d exp=3", n1);
      end
      checks++;
      if (n3 != 5) begin
         failures++;
         $display("FAIL latency_lat3 got=%0d exp=5", n3);
      end
   endtask

   task automatic test_row_scaling();
      logic [13:0] e;
      video_on_in = 1'b1;
      pix(1, 17); step();
      for (int r = 0; r <= 12; r++) begin
         pix(r, 17); step();
         e = {7'(r / 6), 7'd2};
         checks++;
         if (wa1 !== e) begin
            failures++;
            $display("FAIL row_scale r=%0d got=%h exp=%h", r, wa1, e);
         end
      end
      for (int r = 13; r <= 767; r++) begin
         pix(r, 17); step();
      end
      checks++;
      if (wa1 !== {7'd127, 7'd2}) begin
         failures++;
         $display("FAIL row_767 got=%h exp=%h", wa1, {7'd127, 7'd2});
      end
      pix(0, 17); step();
      checks++;
      if (wa1 !== {7'd0, 7'd2}) begin
         failures++;
         $display("FAIL row_wrap got=%h exp=%h", wa1, {7'd0, 7'd2});
      end
   endtask

   task automatic test_world_pass();
      video_on_in = 1'b1;
      pix(0, 24); hold();
      checks++;
      if (wp1 !== 2'b11) begin
         failures++;
         $display("FAIL world_11_lat1 got=%h exp=3", wp1);
      end
      checks++;
      if (wp3 !== 2'b11) begin
         failures++;
         $display("FAIL world_11_lat3 got=%h exp=3", wp3);
      end
      pix(0, 8); hold();
      checks++;
      if (wp1 !== 2'b01) begin
         failures++;
         $display("FAIL world_01_lat1 got=%h exp=1", wp1);
      end
      checks++;
      if (wp3 !== 2'b01) begin
         failures++;
         $display("FAIL world_01_lat3 got=%h exp=1", wp3);
      end
   endtask

   task automatic test_icon_window();
      video_on_in = 1'b1;
      loc_x = 7'd10; loc_y = 7'd20; orient = 3'd3;
      pix(5, 0); step();
      pix(0, 0); step();
      pix(115, 76); hold();
      checks++;
      if (ia1 !== 11'h300) begin
         failures++;
         $display("FAIL icon_tl_addr got=%h exp=300", ia1);
      end
      checks++;
      if (ic1 !== 2'b10 || ic3 !== 2'b10) begin
         failures++;
         $display("FAIL icon_tl_data got=%h/%h exp=2/2", ic1, ic3);
      end
      pix(130, 91); hold();
      checks++;
      if (ia1 !== 11'h3FF) begin
         failures++;
         $display("FAIL icon_br_addr got=%h exp=3ff", ia1);
      end
      checks++;
      if (ic1 !== 2'b01) begin
         failures++;
         $display("FAIL icon_br_data got=%h exp=1", ic1);
      end
      pix(115, 92); hold();
      checks++;
      if (ia1 !== 11'd0 || ic1 !== 2'b00) begin
         failures++;
         $display("FAIL icon_right_miss got=%h/%h exp=0/0", ia1, ic1);
      end
      pix(115, 75); hold();
      checks++;
      if (ia1 !== 11'd0 || ic1 !== 2'b00 || ic3 !== 2'b00) begin
         failures++;
         $display("FAIL icon_left_miss got=%h/%h/%h exp=0/0/0", ia1, ic1, ic3);
      end
   endtask

   task automatic test_origin();
      video_on_in = 1'b1;
      loc_x = 7'd0; loc_y = 7'd0; orient = 3'd5;
      pix(3, 0); step();
      pix(0, 0); step();
      checks++;
      if (ia1 !== 11'h554) begin
         failures++;
         $display("FAIL origin_addr got=%h exp=554", ia1);
      end
      hold();
      checks++;
      if (ic1 !== 2'b10) begin
         failures++;
         $display("FAIL origin_data got=%h exp=2", ic1);
      end
      pix(0, 12); hold();
      checks++;
      if (ia1 !== 11'd0 || ic1 !== 2'b00) begin
         failures++;
         $display("FAIL origin_miss got=%h/%h exp=0/0", ia1, ic1);
      end
   endtask

   task automatic test_midframe();
      video_on_in = 1'b1;
      loc_x = 7'd10; loc_y = 7'd20; orient = 3'd3;
      pix(1, 0); step();
      pix(0, 0); step();
      pix(300, 0); loc_x = 7'd40; step();
      pix(120, 76); hold();
      checks++;
      if (ia1 !== 11'h350) begin
         failures++;
         $display("FAIL mid_old_hit got=%h exp=350", ia1);
      end
      pix(120, 316); hold();
      checks++;
      if (ia1 !== 11'd0) begin
         failures++;
         $display("FAIL mid_new_ignored got=%h exp=0", ia1);
      end
      pix(0, 0); step();
      pix(120, 316); hold();
      checks++;
      if (ia1 !== 11'h350) begin
         failures++;
         $display("FAIL next_new_hit got=%h exp=350", ia1);
      end
      pix(120, 76); hold();
      checks++;
      if (ia1 !== 11'd0) begin
         failures++;
         $display("FAIL next_old_miss got=%h exp=0", ia1);
      end
   endtask

   task automatic test_video_sync();
      bit hp[10] = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 0};
      bit vp[10] = '{0, 0, 1, 1, 1, 0, 0, 0, 0, 0};
      int i1, i3;
      logic [1:0] e1, e3;
      pix(120, 316); video_on_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
      hold();
      checks++;
      if (ia1 !== 11'd0 || ic1 !== 2'b00 || wp1 !== 2'b00) begin
         failures++;
         $display("FAIL blank_icon_world got=%h/%h/%h exp=0/0/0", ia1, ic1, wp1);
      end
      checks++;
      if (vo1 !== 1'b0 || vo3 !== 1'b0 || wp3 !== 2'b00) begin
         failures++;
         $display("FAIL blank_video got=%b/%b/%h exp=0/0/0", vo1, vo3, wp3);
      end
      for (int k = 0; k < 10; k++) begin
         hsync_in = hp[k]; vsync_in = vp[k];
         step();
         i1 = k + 1 - 3;
         i3 = k + 1 - 5;
         e1 = (i1 >= 0) ? {hp[i1], vp[i1]} : 2'b00;
         e3 = (i3 >= 0) ? {hp[i3], vp[i3]} : 2'b00;
         checks++;
         if ({hs1, vs1} !== e1) begin
            failures++;
            $display("FAIL sync_lat1 k=%0d got=%b exp=%b", k, {hs1, vs1}, e1);
         end
         checks++;
         if ({hs3, vs3} !== e3) begin
            failures++;
            $display("FAIL sync_lat3 k=%0d got=%b exp=%b", k, {hs3, vs3}, e3);
         end
      end
   endtask

   task automatic test_reset_midframe();
      video_on_in = 1'b1;
      pix(200, 40);
      step();
      reset = 1'b1;
      step();
      checks++;
      if ({wa1, ia1, wp1, ic1, vo1, hs1, vs1} !== 32'd0) begin
         failures++;
         $display("FAIL midreset_outs got=%h exp=0", {wa1, ia1, wp1, ic1, vo1, hs1, vs1});
      end
      reset = 1'b0;
      loc_x = 7'd40; loc_y = 7'd20; orient = 3'd6;
      pix(0, 0);
      step();
      checks++;
      if (ia1 !== 11'h054) begin
         failures++;
         $display("FAIL midreset_latch got=%h exp=054", ia1);
      end
      step();
      checks++;
      if (vo1 !== 1'b0) begin
         failures++;
         $display("FAIL midreset_blank got=%b exp=0", vo1);
      end
      step();
      checks++;
      if (vo1 !== 1'b1) begin
         failures++;
         $display("FAIL midreset_resume got=%b exp=1", vo1);
      end
   endtask

   initial begin
      test_reset();
      test_row_scaling();
      test_world_pass();
      test_icon_window();
      test_origin();
      test_midframe();
      test_video_sync();
      test_reset_midframe();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pixel_fetch_sequencer.md
Name: pixel_fetch_sequencer

Overview:
Sequences the per-pixel memory lookups that feed the colorizer. From DTG scan coordinates it generates world-map and icon ROM addresses, and latches the Rojobot position/orientation once per frame. It masks the icon outside the 16x16 robot window and delays video_on/hsync/vsync so all colorizer inputs arrive cycle-aligned. It sits between the DTG, the world_map/icon ROMs, and the colorizer.

Parameters:
RD_LAT, 1, read latency in clocks of both world-map and icon ROMs (legal 1..3)

Ports:
clk  in  1  pixel clock
reset  in  1  synchronous, active-high reset
pixel_row  in  10  DTG row, 0..767
pixel_column  in  10  DTG column, 0..1023
video_on_in  in  1  DTG active-video flag
hsync_in  in  1  DTG hsync
vsync_in  in  1  DTG vsync
loc_x  in  7  robot map column, 0..127
loc_y  in  7  robot map row, 0..127
orient  in  3  robot heading, 0..7 (45 deg steps)
world_addr  out  14  world-map ROM address {map_row[6:0], map_col[6:0]}
icon_addr  out  11  icon ROM address {orient_l[2:0], iy[3:0], ix[3:0]}
world_data  in  2  world-map ROM data, valid RD_LAT clocks after world_addr
icon_data  in  2  icon ROM data, valid RD_LAT clocks after icon_addr
world_pixel  out  2  to colorizer world_pixel
icon  out  2  to colorizer icon; 2'b00 = transparent
video_on_out  out  1  aligned video_on
hsync_out  out  1  aligned hsync
vsync_out  out  1  aligned vsync

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port reset.
- Reset: world_addr=0, icon_addr=0, world_pixel=0, icon=0, video_on_out=0, hsync_out=0, vsync_out=0. Latched loc/orient=0, map_row=0, row_sub=0, prev_row=0. All delay-line stages clear.
- Stage A (1 clk after inputs): world_addr and icon_addr registered. icon_hit registered and pushed into the delay line.
- Column scaling: map_col = pixel_column[9:3] (8 screen px per map cell).
- Row scaling (768/6 = 128) uses counters, never a divider. prev_row holds the last pixel_row.
  - pixel_row != prev_row and pixel_row == 0: map_row=0, row_sub=0 (frame start).
  - pixel_row != prev_row, otherwise: if row_sub==5 then row_sub=0 and map_row++ (saturate at 127), else row_sub++.
  - pixel_row == prev_row: counters hold.
- Frame latch: on the frame-start event only, loc_x/loc_y/orient are captured into loc_x_l/loc_y_l/orient_l.
  - The latch takes effect for the first pixel of row 0, the same cycle as the event.
  - Changes mid-frame are ignored until the next frame.
- Icon window, computed in 12-bit signed: x0 = 8*loc_x_l - 4; y0 = 6*loc_y_l - 5 (6*y computed as (y<<2)+(y<<1)). The icon is centred on cell centre (8x+4, 6y+3).
  - dx = pixel_column - x0; dy = pixel_row - y0.
  - icon_hit = (0<=dx<16) and (0<=dy<16) and video_on_in.
  - ix=dx[3:0], iy=dy[3:0]; icon_addr is 0 when icon_hit is 0.
  - A window partially off-screen (negative x0/y0 or beyond 1023/767) clips naturally, with no wrap.
- Delay lines: video_on, hsync, vsync, and icon_hit each delayed so outputs are aligned. Total latency L = RD_LAT + 2 clocks: X_out(t) = X_in(t-L).
- Output stage, registered (same cycle ROM data is valid, plus one register):
  - world_pixel = world_data, or 0 when delayed video_on is 0.
  - icon = icon_data if delayed icon_hit else 2'b00.
- world_data value 2'b11 passes through unchanged; the colorizer owns the interpretation.
- Reset mid-frame: everything clears next clk. The latch keeps loc=0 until the next frame-start event. Outputs are blank for L clocks after reset deassert.

Test Plan:
1. Reset held 3 clks with random inputs -> every output 0. Release with video_on_in=1 -> video_on_out rises exactly RD_LAT+2 clks later (check RD_LAT=1 and 3).
2. Scan rows 0..12, column 17 -> world_addr row field 0 for rows 0-5, 1 for rows 6-11, 2 at row 12; column field = 2. Full frame: row 767 -> map_row 127; row 0 of next frame -> 0.
3. loc_x=10, loc_y=20, orient=3 latched -> x0=76, y0=115.
   - Pixel (col 76, row 115) -> icon_addr = {3'd3,4'd0,4'd0}.
   - (91,130) -> {3,15,15}.
   - (92,115) and (75,115) -> icon=2'b00 regardless of icon_data.
4. loc_x=0, loc_y=0 -> x0=-4, y0=-5. Pixel (0,0) -> ix=4, iy=5, hit. Pixel (12,0) -> no hit.
5. Change loc_x 10->40 at row 300 -> window stays at x0=76 for the rest of the frame; moves to x0=316 after pixel_row returns to 0.
6. video_on_in=0 inside icon window -> icon=0, world_pixel=0, video_on_out=0 after L clks. hsync/vsync pulses are reproduced with the same delay L and width.
